// File: rtl/bus_return_scheduler_if.sv
// Bundle between the requester ports, the shared memory port and the
// bus_return_scheduler; master is the environment side, slave the scheduler.
interface bus_return_scheduler_if #(
    parameter int num_buses     = 2,
    parameter int num_buses_log = 1,
    parameter int addr_width    = 32
);
    logic [num_buses-1:0]            req;
    logic [num_buses*addr_width-1:0] req_addr;
    logic [num_buses-1:0]            grant;
    logic                            mem_req_valid;
    logic [addr_width-1:0]           mem_req_addr;
    logic                            mem_req_ready;
    logic                            mem_resp_valid;
    logic [num_buses_log-1:0]        select;
    logic [num_buses-1:0]            resp_valid;
    logic                            busy;

    modport master (
        output req,
        output req_addr,
        output mem_req_ready,
        output mem_resp_valid,
        input  grant,
        input  mem_req_valid,
        input  mem_req_addr,
        input  select,
        input  resp_valid,
        input  busy
    );

    modport slave (
        input  req,
        input  req_addr,
        input  mem_req_ready,
        input  mem_resp_valid,
        output grant,
        output mem_req_valid,
        output mem_req_addr,
        output select,
        output resp_valid,
        output busy
    );
endinterface

// File: rtl/bus_return_scheduler.sv
// Shares one read port among num_buses requesters, one request in flight.
// Define BUS_SCHED_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module bus_return_scheduler #(
    parameter int num_buses     = 2,
    parameter int num_buses_log = 1,
    parameter int addr_width    = 32
) (
    input logic                   clk,
    input logic                   rst,
    bus_return_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [num_buses_log-1:0] owner;
    logic [num_buses_log-1:0] win;
    logic [num_buses-1:0]     win_oh;
    logic [num_buses-1:0]     owner_oh;
    logic [num_buses-1:0]     grant_q;
    logic [addr_width-1:0]    addr_q;
    logic                     any_req;
    logic                     take;

    assign any_req  = |bus.req;
    assign take     = (state == IDLE) && any_req;
    assign win_oh   = num_buses'(1) << win;
    assign owner_oh = num_buses'(1) << owner;

`ifdef BUS_SCHED_ROUND_ROBIN_EN
    logic [num_buses_log-1:0] rr_ptr;
    int                       rr_idx;
    logic                     rr_found;

    // Search starts just past the last winner and wraps.
    always_comb begin
        win      = '0;
        rr_idx   = 0;
        rr_found = 1'b0;
        for (int k = 1; k <= num_buses; k++) begin
            rr_idx = (int'(rr_ptr) + k) % num_buses;
            if (!rr_found && bus.req[rr_idx]) begin
                rr_found = 1'b1;
                win      = num_buses_log'(rr_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= num_buses_log'(num_buses - 1);
        end else if (take) begin
            rr_ptr <= win;
        end
    end
`else
    always_comb begin
        win = '0;
        for (int i = num_buses - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                win = num_buses_log'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   if (bus.mem_req_ready) state_nxt = WAIT;
            WAIT:    if (bus.mem_resp_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Owner and address are captured once at acceptance and held.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= '0;
            owner   <= '0;
            addr_q  <= '0;
        end else begin
            grant_q <= take ? win_oh : '0;
            if (take) begin
                owner  <= win;
                addr_q <= bus.req_addr[win*addr_width +: addr_width];
            end
        end
    end

    assign bus.grant         = grant_q;
    assign bus.mem_req_valid = (state == ISSUE);
    assign bus.mem_req_addr  = addr_q;
    assign bus.select        = owner;
    assign bus.busy          = (state != IDLE);
    assign bus.resp_valid    = (state == WAIT && bus.mem_resp_valid)
                               ? owner_oh : '0;

endmodule

// File: tb/tb_bus_return_scheduler.sv
// Directed plus randomized transactions against a transaction-level model
// of arbitration, address latching and response steering.
module tb_bus_return_scheduler;
    localparam int NB  = 2;
    localparam int NBL = 1;
    localparam int AW  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad   = 0;
    int last_w = NB - 1;
    logic [AW-1:0] addrs [NB];

    bus_return_scheduler_if #(
        .num_buses(NB), .num_buses_log(NBL), .addr_width(AW)
    ) bif ();

    bus_return_scheduler #(
        .num_buses(NB), .num_buses_log(NBL), .addr_width(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_addrs();
        for (int i = 0; i < NB; i++) bif.req_addr[i*AW +: AW] = addrs[i];
    endtask

    function automatic int pick(input logic [NB-1:0] m);
`ifdef BUS_SCHED_ROUND_ROBIN_EN
        for (int k = 1; k <= NB; k++) begin
            int j = (last_w + k) % NB;
            if (m[j]) return j;
        end
`else
        for (int i = 0; i < NB; i++) if (m[i]) return i;
`endif
        return 0;
    endfunction

    // One full transaction starting in IDLE: rd cycles of backpressure,
    // dly cycles of WAIT before the response, optional spurious response
    // during ISSUE, keep=1 leaves the winner's req asserted.
    task automatic do_txn(input logic [NB-1:0] m, input int rd,
                          input int dly, input bit keep, input bit spur);
        int w;
        logic [NB-1:0] oh;
        logic [AW-1:0] a;
        w = pick(m);
        oh = '0;
        oh[w] = 1'b1;
        a = addrs[w];
        last_w = w;
        bif.req = m;
        #1;
        chk("idle_busy", bif.busy, 0);
        chk("idle_grant", bif.grant, 0);
        step();
        chk("grant", bif.grant, oh);
        chk("issue_valid", bif.mem_req_valid, 1);
        chk("issue_addr", bif.mem_req_addr, a);
        chk("issue_select", bif.select, w);
        chk("issue_busy", bif.busy, 1);
        if (!keep) bif.req = m & ~oh;
        bif.req_addr = ~bif.req_addr;
        bif.mem_req_ready = (rd == 0);
        bif.mem_resp_valid = spur;
        #1;
        chk("issue_resp", bif.resp_valid, 0);
        for (int i = 1; i <= rd; i++) begin
            step();
            bif.mem_resp_valid = 1'b0;
            chk("bp_grant", bif.grant, 0);
            chk("bp_valid", bif.mem_req_valid, 1);
            chk("bp_addr", bif.mem_req_addr, a);
            if (i == rd) bif.mem_req_ready = 1'b1;
        end
        step();
        bif.mem_req_ready = 1'b0;
        bif.mem_resp_valid = 1'b0;
        chk("wait_valid", bif.mem_req_valid, 0);
        chk("wait_busy", bif.busy, 1);
        chk("wait_select", bif.select, w);
        chk("wait_grant", bif.grant, 0);
        for (int j = 0; j < dly; j++) begin
            #1;
            chk("wait_resp", bif.resp_valid, 0);
            step();
            chk("wait_hold", bif.busy, 1);
        end
        bif.mem_resp_valid = 1'b1;
        #1;
        chk("resp", bif.resp_valid, oh);
        step();
        bif.mem_resp_valid = 1'b0;
        #1;
        chk("done_busy", bif.busy, 0);
        chk("done_resp", bif.resp_valid, 0);
        chk("done_valid", bif.mem_req_valid, 0);
        chk("done_select", bif.select, w);
    endtask

    initial begin
        bif.req = '0;
        bif.req_addr = '0;
        bif.mem_req_ready = 1'b0;
        bif.mem_resp_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        chk("rst_grant", bif.grant, 0);
        chk("rst_valid", bif.mem_req_valid, 0);
        chk("rst_addr", bif.mem_req_addr, 0);
        chk("rst_select", bif.select, 0);
        chk("rst_busy", bif.busy, 0);
        chk("rst_resp", bif.resp_valid, 0);
        rst = 1'b0;
        step();
        chk("idle_busy0", bif.busy, 0);

        addrs[0] = 32'hdead_0000;
        addrs[1] = 32'h0000_1040;
        drive_addrs();
        do_txn(2'b10, 0, 2, 0, 0);

        addrs[0] = 32'h0000_2200;
        drive_addrs();
        do_txn(2'b01, 4, 1, 0, 0);

        addrs[0] = 32'h0000_3000;
        addrs[1] = 32'h0000_3100;
        for (int n = 0; n < 3; n++) begin
            drive_addrs();
            do_txn(2'b11, 0, 1, 1, 0);
        end
        bif.req = '0;

        bif.mem_resp_valid = 1'b1;
        #1;
        chk("spur_idle_resp", bif.resp_valid, 0);
        step();
        bif.mem_resp_valid = 1'b0;
        chk("spur_idle_busy", bif.busy, 0);
        chk("spur_idle_grant", bif.grant, 0);
        drive_addrs();
        do_txn(2'b01, 2, 1, 0, 1);

        drive_addrs();
        bif.req = 2'b01;
        step();
        chk("rw_grant", bif.grant, 2'b01);
        bif.req = '0;
        bif.mem_req_ready = 1'b1;
        step();
        bif.mem_req_ready = 1'b0;
        chk("rw_busy", bif.busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_w = NB - 1;
        bif.mem_resp_valid = 1'b1;
        #1;
        chk("rw_resp", bif.resp_valid, 0);
        chk("rw_idle", bif.busy, 0);
        chk("rw_select", bif.select, 0);
        chk("rw_valid", bif.mem_req_valid, 0);
        step();
        bif.mem_resp_valid = 1'b0;
        chk("rw_after", bif.busy, 0);
        addrs[1] = 32'h0000_4444;
        drive_addrs();
        do_txn(2'b10, 1, 0, 0, 0);

        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < NB; i++) addrs[i] = $urandom;
            drive_addrs();
            do_txn(NB'($urandom_range(1, (1 << NB) - 1)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
